// File: rtl/eep_arb_pkg.sv
// Shared types and widths for the EEPROM access arbiter.
package eep_arb_pkg;

   localparam int EEP_AW = 2;
   localparam int EEP_DW = 14;

   typedef enum logic [1:0] {IDLE, RD, WR, VFY} state_t;
   typedef enum logic {OWN_CTRL, OWN_CMD} owner_t;

endpackage

// File: rtl/eep_arb_if.sv
// Requester handshakes and EEPROM pins of the arbiter, bundled for port connection.
interface eep_arb_if;
   import eep_arb_pkg::*;

   logic              ctrl_req;
   logic [EEP_AW-1:0] ctrl_addr;
   logic              ctrl_done;
   logic              cmd_req;
   logic              cmd_wr;
   logic [EEP_AW-1:0] cmd_addr;
   logic [EEP_DW-1:0] cmd_wr_data;
   logic              cmd_done;
   logic              cmd_err;
   logic [EEP_DW-1:0] rd_data;
   logic              busy;
   logic [EEP_AW-1:0] eep_addr;
   logic              eep_cs_n;
   logic              eep_r_w_n;
   logic              chrg_pmp_en;
   logic [EEP_DW-1:0] eep_wr_data;
   logic [EEP_DW-1:0] eep_rd_data;

   modport slave (
      input  ctrl_req, ctrl_addr, cmd_req, cmd_wr, cmd_addr, cmd_wr_data, eep_rd_data,
      output ctrl_done, cmd_done, cmd_err, rd_data, busy,
             eep_addr, eep_cs_n, eep_r_w_n, chrg_pmp_en, eep_wr_data
   );

   modport master (
      output ctrl_req, ctrl_addr, cmd_req, cmd_wr, cmd_addr, cmd_wr_data, eep_rd_data,
      input  ctrl_done, cmd_done, cmd_err, rd_data, busy,
             eep_addr, eep_cs_n, eep_r_w_n, chrg_pmp_en, eep_wr_data
   );

endinterface

// File: rtl/eep_chrg_timer.sv
// Charge-pump down-counter: load starts a write window, expire_o marks its last cycle.
module eep_chrg_timer #(
   parameter int CHRG_CYCLES = 2400000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int            CW       = $clog2(CHRG_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(CHRG_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count was loaded with the full window, so the value 1 is the final enabled cycle.
   assign expire_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/eep_arb.sv
// EEPROM arbiter/sequencer between the PID sequencer (ctrl) and UART interpreter (cmd).
// Optional write readback check enabled by defining EEP_WR_VERIFY_EN.
module eep_arb
   import eep_arb_pkg::*;
#(
   parameter int CHRG_CYCLES = 2400000,
   parameter int MAX_DEFER   = 4
) (
   input logic         clk,
   input logic         rst,
   eep_arb_if.slave    bus
);

   localparam int             DFW       = $clog2(MAX_DEFER + 1);
   localparam logic [DFW-1:0] DEFER_MAX = DFW'(MAX_DEFER);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [DFW-1:0]    defer_q, defer_d;
   logic [EEP_AW-1:0] eep_addr_q, eep_addr_d;
   logic [EEP_DW-1:0] eep_wr_data_q, eep_wr_data_d;
   logic [EEP_DW-1:0] rd_data_q, rd_data_d;
   logic              eep_cs_n_q, eep_cs_n_d;
   logic              eep_r_w_n_q, eep_r_w_n_d;
   logic              chrg_q, chrg_d;
   logic              ctrl_done_q, ctrl_done_d;
   logic              cmd_done_q, cmd_done_d;
   logic              cmd_err_q, cmd_err_d;
   logic              tmr_load, tmr_en, tmr_expire;
   logic              grant_cmd;

   eep_chrg_timer #(.CHRG_CYCLES(CHRG_CYCLES)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   // Pin values are computed one cycle ahead so every EEPROM pin comes straight off a flop.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      defer_d       = defer_q;
      eep_addr_d    = eep_addr_q;
      eep_wr_data_d = eep_wr_data_q;
      rd_data_d     = rd_data_q;
      eep_cs_n_d    = 1'b1;
      eep_r_w_n_d   = 1'b1;
      chrg_d        = 1'b0;
      ctrl_done_d   = 1'b0;
      cmd_done_d    = 1'b0;
      cmd_err_d     = 1'b0;
      tmr_load      = 1'b0;
      tmr_en        = 1'b0;
      grant_cmd     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.cmd_req) begin
               defer_d = '0;
            end
            // A done cycle never arbitrates, so a req the requester is still dropping is ignored.
            if (!ctrl_done_q && !cmd_done_q) begin
               grant_cmd = bus.cmd_req && (!bus.ctrl_req || (defer_q == DEFER_MAX));
               if (grant_cmd) begin
                  owner_d    = OWN_CMD;
                  eep_addr_d = bus.cmd_addr;
                  defer_d    = '0;
                  eep_cs_n_d = 1'b0;
                  if (bus.cmd_wr) begin
                     state_d       = WR;
                     eep_r_w_n_d   = 1'b0;
                     chrg_d        = 1'b1;
                     eep_wr_data_d = bus.cmd_wr_data;
                     tmr_load      = 1'b1;
                  end else begin
                     state_d = RD;
                  end
               end else if (bus.ctrl_req) begin
                  owner_d    = OWN_CTRL;
                  eep_addr_d = bus.ctrl_addr;
                  eep_cs_n_d = 1'b0;
                  state_d    = RD;
                  if (bus.cmd_req && (defer_q < DEFER_MAX)) begin
                     defer_d = defer_q + 1'b1;
                  end
               end
            end
         end

         RD: begin
            rd_data_d = bus.eep_rd_data;
            state_d   = IDLE;
            if (owner_q == OWN_CTRL) begin
               ctrl_done_d = 1'b1;
            end else begin
               cmd_done_d = 1'b1;
            end
         end

         WR: begin
            tmr_en = 1'b1;
            if (tmr_expire) begin
`ifdef EEP_WR_VERIFY_EN
               state_d    = VFY;
               eep_cs_n_d = 1'b0;
`else
               state_d    = IDLE;
               cmd_done_d = 1'b1;
`endif
            end else begin
               eep_cs_n_d  = 1'b0;
               eep_r_w_n_d = 1'b0;
               chrg_d      = 1'b1;
            end
         end

`ifdef EEP_WR_VERIFY_EN
         VFY: begin
            rd_data_d  = bus.eep_rd_data;
            cmd_err_d  = (bus.eep_rd_data != eep_wr_data_q);
            cmd_done_d = 1'b1;
            state_d    = IDLE;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= OWN_CTRL;
         defer_q       <= '0;
         eep_addr_q    <= '0;
         eep_wr_data_q <= '0;
         rd_data_q     <= '0;
         eep_cs_n_q    <= 1'b1;
         eep_r_w_n_q   <= 1'b1;
         chrg_q        <= 1'b0;
         ctrl_done_q   <= 1'b0;
         cmd_done_q    <= 1'b0;
         cmd_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         defer_q       <= defer_d;
         eep_addr_q    <= eep_addr_d;
         eep_wr_data_q <= eep_wr_data_d;
         rd_data_q     <= rd_data_d;
         eep_cs_n_q    <= eep_cs_n_d;
         eep_r_w_n_q   <= eep_r_w_n_d;
         chrg_q        <= chrg_d;
         ctrl_done_q   <= ctrl_done_d;
         cmd_done_q    <= cmd_done_d;
         cmd_err_q     <= cmd_err_d;
      end
   end

   assign bus.ctrl_done   = ctrl_done_q;
   assign bus.cmd_done    = cmd_done_q;
   assign bus.cmd_err     = cmd_err_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.eep_addr    = eep_addr_q;
   assign bus.eep_cs_n    = eep_cs_n_q;
   assign bus.eep_r_w_n   = eep_r_w_n_q;
   assign bus.chrg_pmp_en = chrg_q;
   assign bus.eep_wr_data = eep_wr_data_q;

endmodule

// File: tb/tb_eep_arb.sv
// Self-checking bench for eep_arb: directed table, corner sequences, then random traffic.
module tb_eep_arb;
   import eep_arb_pkg::*;

   localparam int CHRG  = 16;
   localparam int MAXD  = 4;
`ifdef EEP_WR_VERIFY_EN
   localparam int V     = 1;
`else
   localparam int V     = 0;
`endif
   localparam int CTRL_BOUND = CHRG + 4 + V;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic corrupt = 1'b0;

   eep_arb_if bus();

   eep_arb #(.CHRG_CYCLES(CHRG), .MAX_DEFER(MAXD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // EEPROM device model: combinational read, write committed while the pump is on.
   logic [13:0] dev_mem [4] = '{14'h1555, 14'h0AAA, 14'h0123, 14'h3C3C};
   assign bus.eep_rd_data = dev_mem[bus.eep_addr] ^ {13'b0, corrupt};
   always @(posedge clk) begin
      if (!bus.eep_cs_n && !bus.eep_r_w_n && bus.chrg_pmp_en) begin
         dev_mem[bus.eep_addr] <= bus.eep_wr_data;
      end
   end

   typedef struct {
      bit          is_cmd;
      bit          wr;
      logic [1:0]  addr;
      logic [13:0] wdata;
      logic [13:0] exp_rd;
   } vec_t;

   vec_t        vecs [8];
   int          vectors = 0;
   int          miscompares = 0;
   logic [13:0] ref_mem [4] = '{14'h1555, 14'h0AAA, 14'h0123, 14'h3C3C};
   logic [13:0] last_rd;

   int lat, cs_cnt, chrg_cnt, other_done, err_v, rd_v, k, stable, got, n;
   int order [10];
   bit ctrl_pend, cmd_pend, cmd_w, draining;
   logic [1:0]  ctrl_a, cmd_a;
   logic [13:0] cmd_d;
   int ctrl_wait, cmd_wait, chrg_run, cs_run, last_cs_run, cmd_bound;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // One isolated transaction; requester inputs are scrambled after grant to prove latching.
   task automatic applyStimulus(input vec_t v, output int o_lat, output int o_cs, output int o_chrg,
                                output int o_other, output int o_err, output int o_rd);
      bit done_seen;
      @(negedge clk);
      if (v.is_cmd) begin
         bus.cmd_req = 1'b1; bus.cmd_wr = v.wr; bus.cmd_addr = v.addr; bus.cmd_wr_data = v.wdata;
      end else begin
         bus.ctrl_req = 1'b1; bus.ctrl_addr = v.addr;
      end
      o_lat = 0; o_cs = 0; o_chrg = 0; o_other = 0; done_seen = 1'b0;
      while (!done_seen && o_lat < 100) begin
         @(negedge clk);
         o_lat++;
         if (!bus.eep_cs_n) o_cs++;
         if (bus.chrg_pmp_en) o_chrg++;
         if (v.is_cmd ? bus.ctrl_done : bus.cmd_done) o_other++;
         done_seen = v.is_cmd ? bus.cmd_done : bus.ctrl_done;
         if (!done_seen) begin
            bus.ctrl_addr   = 2'($urandom);
            bus.cmd_addr    = 2'($urandom);
            bus.cmd_wr      = 1'($urandom);
            bus.cmd_wr_data = 14'($urandom);
         end
      end
      o_err = int'(bus.cmd_err);
      o_rd  = int'(bus.rd_data);
      bus.ctrl_req = 1'b0;
      bus.cmd_req  = 1'b0;
   endtask

   initial begin
      bus.ctrl_req = 1'b0; bus.ctrl_addr = '0;
      bus.cmd_req = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_wr_data = '0;

      vecs[0] = '{1'b1, 1'b1, 2'd1, 14'h2A5A, (V == 1) ? 14'h2A5A : 14'h0000};
      vecs[1] = '{1'b0, 1'b0, 2'd2, 14'h0000, 14'h0123};
      vecs[2] = '{1'b1, 1'b0, 2'd1, 14'h0000, 14'h2A5A};
      vecs[3] = '{1'b0, 1'b0, 2'd1, 14'h0000, 14'h2A5A};
      vecs[4] = '{1'b1, 1'b1, 2'd3, 14'h3FFF, (V == 1) ? 14'h3FFF : 14'h2A5A};
      vecs[5] = '{1'b0, 1'b0, 2'd3, 14'h0000, 14'h3FFF};
      vecs[6] = '{1'b1, 1'b0, 2'd0, 14'h0000, 14'h1555};
      vecs[7] = '{1'b0, 1'b0, 2'd0, 14'h0000, 14'h1555};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_cs_n", bus.eep_cs_n, 1);
      checkOutput("rst_r_w_n", bus.eep_r_w_n, 1);
      checkOutput("rst_chrg", bus.chrg_pmp_en, 0);
      checkOutput("rst_addr", bus.eep_addr, 0);
      checkOutput("rst_wr_data", bus.eep_wr_data, 0);
      checkOutput("rst_rd_data", bus.rd_data, 0);
      checkOutput("rst_dones", {bus.ctrl_done, bus.cmd_done, bus.cmd_err}, 0);
      checkOutput("rst_busy", bus.busy, 0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], lat, cs_cnt, chrg_cnt, other_done, err_v, rd_v);
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].wr ? CHRG + 1 + V : 2);
         checkOutput($sformatf("vec%0d_cs_cycles", i), cs_cnt, vecs[i].wr ? CHRG + V : 1);
         checkOutput($sformatf("vec%0d_chrg_cycles", i), chrg_cnt, vecs[i].wr ? CHRG : 0);
         checkOutput($sformatf("vec%0d_other_done", i), other_done, 0);
         checkOutput($sformatf("vec%0d_err", i), err_v, 0);
         checkOutput($sformatf("vec%0d_rd_data", i), rd_v, int'(vecs[i].exp_rd));
         if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
      end

      // ctrl_req arrives in write cycle 5 and must wait for the whole write.
      @(negedge clk);
      bus.cmd_req = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 2'd2; bus.cmd_wr_data = 14'h1111;
      k = 0; stable = 1; got = 0;
      while (got == 0 && k < 100) begin
         @(negedge clk);
         k++;
         got = int'(bus.cmd_done);
         if (got == 0 && k <= CHRG && (bus.eep_addr != 2'd2 || bus.eep_r_w_n || !bus.chrg_pmp_en ||
             bus.eep_cs_n || bus.eep_wr_data != 14'h1111)) stable = 0;
         if (bus.ctrl_done) stable = 0;
         if (k == 5) begin bus.ctrl_req = 1'b1; bus.ctrl_addr = 2'd0; end
      end
      bus.cmd_req = 1'b0;
      ref_mem[2] = 14'h1111;
      checkOutput("wr_done_latency", k, CHRG + 1 + V);
      checkOutput("wr_pins_stable", stable, 1);
      @(negedge clk);
      checkOutput("ctrl_arb_cycle_cs_n", bus.eep_cs_n, 1);
      @(negedge clk);
      checkOutput("ctrl_grant_cs_n", bus.eep_cs_n, 0);
      checkOutput("ctrl_grant_addr", bus.eep_addr, 0);
      checkOutput("ctrl_grant_r_w_n", bus.eep_r_w_n, 1);
      @(negedge clk);
      checkOutput("ctrl_done_after_wr", bus.ctrl_done, 1);
      checkOutput("ctrl_rd_after_wr", bus.rd_data, 14'h1555);
      bus.ctrl_req = 1'b0;

      // Both requesters held: fairness grants cmd after MAX_DEFER ctrl reads.
      @(negedge clk);
      bus.ctrl_req = 1'b1; bus.ctrl_addr = 2'd2;
      bus.cmd_req = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 2'd3;
      n = 0; k = 0;
      while (n < 10 && k < 200) begin
         @(negedge clk);
         k++;
         if (bus.ctrl_done) begin order[n] = 0; n++; bus.ctrl_req = 1'b0; end
         else if (!bus.ctrl_req) bus.ctrl_req = 1'b1;
         if (bus.cmd_done) begin if (n < 10) order[n] = 1; n++; bus.cmd_req = 1'b0; end
         else if (!bus.cmd_req) bus.cmd_req = 1'b1;
      end
      bus.ctrl_req = 1'b0; bus.cmd_req = 1'b0;
      checkOutput("fair_grant_count", n, 10);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("fair_order%0d", i), (i < n) ? order[i] : -1, (i == 4 || i == 9) ? 1 : 0);
      end
      repeat (4) @(negedge clk);

      // Reset in write cycle 8 aborts the write with no completion.
      bus.cmd_req = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 2'd1; bus.cmd_wr_data = 14'h2A5A;
      repeat (8) @(negedge clk);
      checkOutput("abort_pre_chrg", bus.chrg_pmp_en, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_chrg", bus.chrg_pmp_en, 0);
      checkOutput("abort_cs_n", bus.eep_cs_n, 1);
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_done", {bus.cmd_done, bus.cmd_err}, 0);
      rst = 1'b0; bus.cmd_req = 1'b0;
      got = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.cmd_done || bus.ctrl_done || !bus.eep_cs_n) got++;
      end
      checkOutput("abort_no_activity", got, 0);

      // Readback corruption: flagged only when the verify cycle exists.
      corrupt = 1'b1;
      applyStimulus('{1'b1, 1'b1, 2'd0, 14'h0F0F, 14'h0}, lat, cs_cnt, chrg_cnt, other_done, err_v, rd_v);
      corrupt = 1'b0;
      ref_mem[0] = 14'h0F0F;
      checkOutput("corrupt_latency", lat, CHRG + 1 + V);
      checkOutput("corrupt_err", err_v, V);
      checkOutput("corrupt_rd_data", rd_v, (V == 1) ? 14'h0F0E : 14'h0000);
      last_rd = (V == 1) ? 14'h0F0E : 14'h0000;

      // Random traffic against a transaction-level model with latency bounds.
      ctrl_pend = 0; cmd_pend = 0; draining = 0;
      chrg_run = 0; cs_run = 0; last_cs_run = 0;
      for (int cyc = 0; cyc < 3000 && (!draining || ctrl_pend || cmd_pend); cyc++) begin
         if (cyc >= 2600) draining = 1;
         @(negedge clk);
         if (ctrl_pend) ctrl_wait++;
         if (cmd_pend) cmd_wait++;
         if (bus.chrg_pmp_en) chrg_run++;
         else if (chrg_run != 0) begin checkOutput("rnd_chrg_run", chrg_run, CHRG); chrg_run = 0; end
         if (!bus.eep_cs_n) cs_run++;
         else if (cs_run != 0) begin last_cs_run = cs_run; cs_run = 0; end

         if (bus.ctrl_done) begin
            checkOutput("rnd_ctrl_done_expected", ctrl_pend, 1);
            checkOutput("rnd_ctrl_rd_data", bus.rd_data, ref_mem[ctrl_a]);
            checkOutput("rnd_ctrl_wait_ok", ctrl_wait <= CTRL_BOUND, 1);
            checkOutput("rnd_ctrl_cs_cycles", last_cs_run, 1);
            last_rd = ref_mem[ctrl_a];
            ctrl_pend = 0; bus.ctrl_req = 1'b0;
         end else if (ctrl_pend && ctrl_wait > CTRL_BOUND + 2) begin
            checkOutput("rnd_ctrl_timeout", ctrl_wait, CTRL_BOUND);
            ctrl_pend = 0; bus.ctrl_req = 1'b0;
         end

         cmd_bound = 3 * MAXD + 4 + (cmd_w ? CHRG - 1 + V : 0);
         if (bus.cmd_done) begin
            checkOutput("rnd_cmd_done_expected", cmd_pend, 1);
            checkOutput("rnd_cmd_err", bus.cmd_err, 0);
            checkOutput("rnd_cmd_wait_ok", cmd_wait <= cmd_bound, 1);
            checkOutput("rnd_cmd_cs_cycles", last_cs_run, cmd_w ? CHRG + V : 1);
            if (cmd_w) begin
               ref_mem[cmd_a] = cmd_d;
               if (V == 1) last_rd = cmd_d;
            end else begin
               last_rd = ref_mem[cmd_a];
            end
            checkOutput("rnd_cmd_rd_data", bus.rd_data, last_rd);
            cmd_pend = 0; bus.cmd_req = 1'b0;
         end else if (cmd_pend && cmd_wait > cmd_bound + 2) begin
            checkOutput("rnd_cmd_timeout", cmd_wait, cmd_bound);
            cmd_pend = 0; bus.cmd_req = 1'b0;
         end

         if (!bus.ctrl_done && !bus.cmd_done) checkOutput("rnd_rd_data_hold", bus.rd_data, last_rd);

         if (!draining && !ctrl_pend && !bus.ctrl_done && $urandom_range(0, 3) == 0) begin
            ctrl_pend = 1; ctrl_wait = 0; ctrl_a = 2'($urandom);
            bus.ctrl_req = 1'b1; bus.ctrl_addr = ctrl_a;
         end
         if (!draining && !cmd_pend && !bus.cmd_done && $urandom_range(0, 3) == 0) begin
            cmd_pend = 1; cmd_wait = 0; cmd_a = 2'($urandom); cmd_d = 14'($urandom);
            cmd_w = ($urandom_range(0, 3) == 0);
            bus.cmd_req = 1'b1; bus.cmd_wr = cmd_w; bus.cmd_addr = cmd_a; bus.cmd_wr_data = cmd_d;
         end
      end
      checkOutput("rnd_drained", ctrl_pend || cmd_pend, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/eep_arb.md
# eep_arb

EEPROM access arbiter and sequencer sharing the single 4-word × 14-bit calibration EEPROM between the PID control sequencer (coefficient/setpoint reads) and the UART command interpreter (reads and charge-pumped writes). It owns every EEPROM pin: address, chip select, read/write, and charge-pump enable. It also enforces write charge-pump timing and bounded-latency fairness. Both requesters see a uniform req/done handshake, so neither touches EEPROM pins directly.

## Interface
- CHRG_CYCLES, 2400000: cycles charge pump stays enabled per write (3 ms).
- MAX_DEFER, 4: consecutive arbitration losses after which cmd wins over ctrl.
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ctrl_req  in  1  PID sequencer read request; held until ctrl_done.
- ctrl_addr  in  2  EEPROM word address for ctrl read.
- ctrl_done  out  1  one-cycle pulse; rd_data valid this cycle.
- cmd_req  in  1  command-interpreter request; held until cmd_done.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  2  word address.
- cmd_wr_data  in  14  write data.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_err  out  1  valid with cmd_done; write-verify mismatch (0 without EEP_WR_VERIFY_EN).
- rd_data  out  14  last read word, held until next read completes.
- busy  out  1  transaction in progress (not IDLE).
- eep_addr  out  2  EEPROM address.
- eep_cs_n  out  1  EEPROM chip select, active-low.
- eep_r_w_n  out  1  1 = read, 0 = write.
- chrg_pmp_en  out  1  charge-pump enable.
- eep_wr_data  out  14  EEPROM write data.
- eep_rd_data  in  14  EEPROM read data, valid same cycle as cs_n low with r_w_n high.

## Operation
- States: IDLE, RD, WR, VFY (VFY only with macro).
- IDLE: pins inactive. Arbitrates only when neither done pulse is high.
  - ctrl_req alone → RD (owner ctrl).
  - cmd_req alone → RD or WR per cmd_wr.
  - Both pending: ctrl wins unless defer_cnt == MAX_DEFER, then cmd wins.
- Grant latches owner, address, r/w and write data. Later changes on requester inputs are ignored until done.
- defer_cnt:
  - +1 each arbitration where cmd_req loses to ctrl.
  - Cleared on any cmd grant, and when cmd_req is low in IDLE.
  - Saturates at MAX_DEFER.
- RD: eep_cs_n=0, eep_r_w_n=1, eep_addr = latched address. eep_rd_data captured into rd_data at the clock edge. → IDLE with owner's done high.
- WR: eep_cs_n=0, eep_r_w_n=0, chrg_pmp_en=1, eep_wr_data and eep_addr held stable. Timer counts CHRG_CYCLES cycles, then → IDLE (or VFY) with cmd_done.
- WR is never preempted. ctrl_req arriving during WR waits and is granted in the first arbitrating IDLE cycle.
- Requester must drop req in its done cycle. A req still high on the following IDLE cycle is a new transaction.
- Req dropped before grant: withdrawn, no done, no pin activity.
- rst mid-transaction: next edge forces IDLE. The aborted write stops immediately, with no done pulse and cmd_err=0.
- Reset values: eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0, eep_addr=0, eep_wr_data=0, rd_data=0, ctrl_done=0, cmd_done=0, cmd_err=0, busy=0, defer_cnt=0, timer=0.

## Timing
- Read: req seen in IDLE cycle N → RD cycle N+1 → done and rd_data valid in cycle N+2. Back-to-back reads by one requester: 3-cycle period.
- Write: WR occupies cycles N+1 … N+CHRG_CYCLES. cmd_done in N+CHRG_CYCLES+1, or N+CHRG_CYCLES+2 with verify.
- chrg_pmp_en high for exactly CHRG_CYCLES cycles per write.
- Worst-case ctrl wait: one full write plus one bubble.
- Worst-case cmd wait: MAX_DEFER ctrl reads.

## Configuration
- EEP_WR_VERIFY_EN defined:
  - WR → VFY: one read cycle of the latched address.
  - cmd_err = (eep_rd_data != latched write data), pulsed with cmd_done.
  - rd_data updated with the readback value.
- Undefined: no VFY state, WR → IDLE directly, cmd_err tied 0.

## Structure
- eep_arb_pkg:
  - State enum {IDLE, RD, WR, VFY}.
  - Owner enum {OWN_CTRL, OWN_CMD}.
  - Constants EEP_AW=2, EEP_DW=14.
- Sub-module eep_chrg_timer:
  - Load/enable down-counter, width $clog2(CHRG_CYCLES+1).
  - Outputs expire pulse.
  - Synchronous active-high reset.

## Test plan
- ctrl_req addr 2, eeprom model word 2 = 14'h0123 → ctrl_done at N+2, rd_data=14'h0123, one cs_n low cycle, r_w_n=1.
- cmd write addr 1 data 14'h2A5A (CHRG_CYCLES=16 in bench) → chrg_pmp_en high exactly 16 cycles, cmd_done cycle 17; subsequent read returns 14'h2A5A.
- ctrl_req raised at write cycle 5 → no pin change until write ends; ctrl granted the cycle after cmd_done.
- ctrl_req and cmd_req both held continuously, MAX_DEFER=4 → grant order ctrl×4, cmd, ctrl×4, cmd.
- rst asserted at write cycle 8 → chrg_pmp_en=0, eep_cs_n=1 after next edge; no cmd_done; busy=0.
- With EEP_WR_VERIFY_EN, model corrupts bit 0 → cmd_done with cmd_err=1; without macro → cmd_err=0.
